// File: rtl/cla_adder_arbiter_if.sv
// Requester and downstream handshake bundle for the shared carry-lookahead adder.
// Requester n uses bit n of i_valid/o_ready and bits [n*WIDTH +: WIDTH] of the operand buses.
interface cla_adder_arbiter_if #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       i_valid;
  logic [NREQ*WIDTH-1:0] i_add1;
  logic [NREQ*WIDTH-1:0] i_add2;
  logic [NREQ-1:0]       o_ready;
  logic                  o_valid;
  logic [WIDTH:0]        o_result;
  logic [IDW-1:0]        o_id;
  logic                  i_ready;

  modport slave (
    input  i_valid, i_add1, i_add2, i_ready,
    output o_ready, o_valid, o_result, o_id
  );

  modport master (
    output i_valid, i_add1, i_add2, i_ready,
    input  o_ready, o_valid, o_result, o_id
  );
endinterface

// File: rtl/cla_adder_arbiter.sv
// One carry-lookahead adder shared by NREQ requesters through a round-robin arbiter,
// with a single-entry tagged result register toward one downstream consumer.
module carry_lookahead_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_term;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a flat OR of generate terms gated by the propagates above them.
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  assign o_sum = {w_c[WIDTH], w_p ^ w_c[WIDTH-1:0]};
endmodule

// state   | meaning
// S_EMPTY | result register holds nothing
// S_FULL  | result register holds a result awaiting downstream
module cla_adder_arbiter #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
) (
  input logic               clk,
  input logic               rst,
  cla_adder_arbiter_if.slave bus
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH:0]   r_result;
  logic [IDW-1:0]   w_gnt_id;
  logic [NREQ-1:0]  w_onehot;
  logic             w_found;
  logic             w_can_accept;
  logic             w_grant;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  int               w_idx;

  // Scan from the pointer, wrapping once; the first valid requester wins.
  always_comb begin
    w_found      = 1'b0;
    w_gnt_id     = '0;
    w_onehot     = '0;
    w_a          = '0;
    w_b          = '0;
    w_idx        = 0;
    w_can_accept = (r_state == S_EMPTY) || bus.i_ready;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.i_valid[w_idx]) begin
        w_found         = 1'b1;
        w_gnt_id        = IDW'(w_idx);
        w_onehot[w_idx] = 1'b1;
        w_a             = bus.i_add1[w_idx*WIDTH +: WIDTH];
        w_b             = bus.i_add2[w_idx*WIDTH +: WIDTH];
      end
    end
    w_grant = w_can_accept && w_found && !rst;
  end

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_grant)          w_state_nxt = S_FULL;
        else if (bus.i_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_ptr    <= '0;
      r_result <= '0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_result <= w_sum;
        r_id     <= w_gnt_id;
        r_ptr    <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

  assign bus.o_ready  = w_grant ? w_onehot : '0;
  assign bus.o_valid  = (r_state == S_FULL);
  assign bus.o_result = r_result;
  assign bus.o_id     = r_id;
endmodule
